rs_div_param: RTL and testbench
===============================

Name: rs_div_param

Overview:
Parametrised reservation station with an embedded iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU. It succeeds the fixed 8-entry, 3-writeback divide station with these additions:
- configurable width, depth and writeback-port count
- oldest-ready issue order
- same-cycle wakeup at dispatch
- RISC-V divide-by-zero and overflow semantics
- valid/ready result handshake
- flush
It sits between dispatch and the common writeback bus.

Parameters:
XLEN, 32, operand/result width
TAG_W, 5, rename tag width
DEPTH, 8, number of station entries (>=2)
NUM_WB, 3, number of writeback snoop ports

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash of all state
in_valid  in  1  dispatch request
in_ready  out  1  station can accept (count < DEPTH)
in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
in_tag  in  TAG_W  destination tag
in_op1_dep  in  1  op1 pending; in_op1[TAG_W-1:0] holds the source tag
in_op1  in  XLEN  op1 value or tag
in_op2_dep  in  1  op2 pending; in_op2[TAG_W-1:0] holds the source tag
in_op2  in  XLEN  op2 value or tag
wb_en  in  NUM_WB  writeback valid per port
wb_tag  in  NUM_WB*TAG_W  packed tags, port 0 in LSBs
wb_val  in  NUM_WB*XLEN  packed values
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_tag  out  TAG_W  result tag
out_val  out  XLEN  result value
count  out  $clog2(DEPTH+1)  live entries

Behaviour:
- Reset (rst=0, async):
  - all entries invalid, count=0
  - divider idle, out_valid=0, out_tag=0, out_val=0
  - in_ready=1 once rst is released
- Accept:
  - Dispatch is accepted on in_valid && in_ready && !flush.
  - The entry is written into the lowest-index free slot.
  - in_ready is combinational from count only.
- Wakeup:
  - Every cycle, each pending operand of a live entry compares its tag with each enabled wb port.
  - On a match, the operand captures the value and clears its dep bit.
  - Lowest port index wins.
  - The same compare applies to the incoming dispatch operands in the accept cycle, so a tag broadcast in that cycle is not lost.
- Age:
  - Entries are ordered by acceptance.
  - Issue picks the oldest entry with both operands ready.
  - An entry woken this cycle is eligible only from the next cycle.
- Issue condition: divider idle AND (out_valid==0 OR out_ready==1) AND a ready entry exists.
- Issue cycle T:
  - The entry is freed at edge T.
  - count is updated at that edge: count_next = count + accept - issue (simultaneous accept and issue leave count unchanged).
  - A slot freed at T is reusable from T+1.
- Divider, normal case:
  - Signed ops take magnitudes and fix signs afterwards.
  - REM takes the sign of the dividend.
  - XLEN iterations; out_valid rises at edge T+XLEN+1.
- Divider, special cases, resolved with out_valid at edge T+1:
  - divisor==0: quotient=all ones, remainder=dividend
  - signed, dividend==MIN and divisor==-1: quotient=MIN, remainder=0
- Output:
  - out_tag/out_val hold stable while out_valid && !out_ready.
  - out_valid drops after the handshake unless a new result lands at the same edge.
  - The divider stays busy until its result is in the output register.
- Flush, at the next edge:
  - all entries invalid, count=0
  - divider aborted to idle, out_valid=0
  - any dispatch in that cycle is dropped
- Full: at count==DEPTH, in_ready=0. An in_valid held with in_ready=0 is ignored and must not corrupt state.

Test Plan:
- Reset mid-divide: issue 100/7, pull rst low at cycle 10 -> out_valid=0 immediately; count=0, in_ready=1 after release; no result appears.
- Ready DIV -7/2 (op 00), then REM -7/2 (op 10) -> out_val 0xFFFFFFFD then 0xFFFFFFFF; first out_valid 34 cycles after accept (XLEN=32); tags preserved.
- DIVU 5/0 -> 0xFFFFFFFF; REM 0x80000000/-1 -> 0; each out_valid 1 cycle after issue.
- Wakeup ordering: dispatch A (op1 waits tag 3), then ready B; wb port1 tag3=42 and port2 tag3=99 together -> A captures 42. After wakeup A is still older, so A issues first if both are ready.
- Fill 8 entries with blocked operands -> count=8, in_ready=0; a 9th in_valid is dropped; a wb frees one -> one issue, in_ready=1.
- Hold out_ready=0 with a result pending -> no new issue, out_val stable; assert flush -> out_valid=0, count=0 next cycle.

Source files
------------

// File: rtl/rs_div_param_if.sv
// Dispatch, writeback-snoop and result channels of the divide reservation station.
// The master drives dispatch/writeback/out_ready; the slave is the station itself.
interface rs_div_param_if #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 3
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic [1:0]              in_op;
    logic [TAG_W-1:0]        in_tag;
    logic                    in_op1_dep;
    logic [XLEN-1:0]         in_op1;
    logic                    in_op2_dep;
    logic [XLEN-1:0]         in_op2;
    logic [NUM_WB-1:0]       wb_en;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic [NUM_WB*XLEN-1:0]  wb_val;
    logic                    out_valid;
    logic                    out_ready;
    logic [TAG_W-1:0]        out_tag;
    logic [XLEN-1:0]         out_val;
    logic [CW-1:0]           count;

    modport master (
        output in_valid, in_op, in_tag, in_op1_dep, in_op1, in_op2_dep, in_op2,
        output wb_en, wb_tag, wb_val, out_ready,
        input  in_ready, out_valid, out_tag, out_val, count
    );

    modport slave (
        input  in_valid, in_op, in_tag, in_op1_dep, in_op1, in_op2_dep, in_op2,
        input  wb_en, wb_tag, wb_val, out_ready,
        output in_ready, out_valid, out_tag, out_val, count
    );
endinterface

// File: rtl/rs_div_param.sv
// Reservation station for RV32M divides: oldest-ready issue into an iterative
// radix-2 restoring divider with RISC-V divide-by-zero/overflow results.
module rs_div_param #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    rs_div_param_if.slave bus
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);
    localparam int ITW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {D_IDLE, D_BUSY, D_FIN} div_state_t;
    div_state_t dstate, dstate_n;

    logic [DEPTH-1:0] e_v, e_d1, e_d2;
    logic [1:0]       e_op   [DEPTH];
    logic [TAG_W-1:0] e_tag  [DEPTH];
    logic [XLEN-1:0]  e_o1   [DEPTH];
    logic [XLEN-1:0]  e_o2   [DEPTH];
    logic [CW-1:0]    e_rank [DEPTH];
    logic [CW-1:0]    cnt;

    logic [XLEN:0]    s1 [DEPTH];
    logic [XLEN:0]    s2 [DEPTH];
    logic [XLEN:0]    in_s1, in_s2;
    logic             accept, issue, sel_found, free_found;
    logic [IW-1:0]    sel_idx, free_idx;
    logic [CW-1:0]    sel_rank;

    logic [XLEN-1:0]  quo, rem, dvs, op_a, op_b, mag_a, mag_b, q_fix, r_fix;
    logic [XLEN:0]    shift, diff;
    logic [ITW-1:0]   it;
    logic [TAG_W-1:0] d_tag;
    logic [1:0]       sel_op;
    logic             d_is_rem, neg_q, neg_r, sgn, a_neg, b_neg, div0, ovf, ge;
    logic             out_v;
    logic [TAG_W-1:0] out_t;
    logic [XLEN-1:0]  out_d;

    // {hit, value}; lowest-index enabled port with a matching tag wins
    function automatic logic [XLEN:0] snoop(input logic [TAG_W-1:0] t,
                                            input logic [NUM_WB-1:0] en,
                                            input logic [NUM_WB*TAG_W-1:0] tags,
                                            input logic [NUM_WB*XLEN-1:0] vals);
        logic [XLEN:0] r;
        r = '0;
        for (int unsigned p = 0; p < NUM_WB; p++)
            if (!r[XLEN] && en[p] && tags[p*TAG_W +: TAG_W] == t)
                r = {1'b1, vals[p*XLEN +: XLEN]};
        return r;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            s1[i] = snoop(e_o1[i][TAG_W-1:0], bus.wb_en, bus.wb_tag, bus.wb_val);
            s2[i] = snoop(e_o2[i][TAG_W-1:0], bus.wb_en, bus.wb_tag, bus.wb_val);
        end
        in_s1 = snoop(bus.in_op1[TAG_W-1:0], bus.wb_en, bus.wb_tag, bus.wb_val);
        in_s2 = snoop(bus.in_op2[TAG_W-1:0], bus.wb_en, bus.wb_tag, bus.wb_val);
    end

    // rank = number of older live entries, so the oldest ready entry has the lowest rank
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_rank   = '1;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (e_v[i] && !e_d1[i] && !e_d2[i] && (!sel_found || e_rank[i] < sel_rank)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                sel_rank  = e_rank[i];
            end
            if (!e_v[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign bus.in_ready  = (cnt != CW'(DEPTH));
    assign bus.count     = cnt;
    assign bus.out_valid = out_v;
    assign bus.out_tag   = out_t;
    assign bus.out_val   = out_d;
    assign accept = bus.in_valid && bus.in_ready && !flush;
    assign issue  = (dstate == D_IDLE) && (!out_v || bus.out_ready) && sel_found && !flush;

    always_comb begin
        sel_op = e_op[sel_idx];
        op_a   = e_o1[sel_idx];
        op_b   = e_o2[sel_idx];
        sgn    = !sel_op[0];
        a_neg  = sgn && op_a[XLEN-1];
        b_neg  = sgn && op_b[XLEN-1];
        mag_a  = a_neg ? -op_a : op_a;
        mag_b  = b_neg ? -op_b : op_b;
        div0   = (op_b == '0);
        ovf    = sgn && (op_a == MIN_VAL) && (op_b == '1);
        shift  = {rem, quo[XLEN-1]};
        diff   = shift - {1'b0, dvs};
        ge     = (shift >= {1'b0, dvs});
        q_fix  = neg_q ? -quo : quo;
        r_fix  = neg_r ? -rem : rem;
    end

    always_comb begin
        dstate_n = dstate;
        unique case (dstate)
            D_IDLE:  if (issue) dstate_n = (div0 || ovf) ? D_FIN : D_BUSY;
            D_BUSY:  if (it == ITW'(XLEN - 1)) dstate_n = D_FIN;
            D_FIN:   dstate_n = D_IDLE;
            default: dstate_n = D_IDLE;
        endcase
        if (flush) dstate_n = D_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dstate <= D_IDLE;
        else      dstate <= dstate_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_v  <= '0;
            e_d1 <= '0;
            e_d2 <= '0;
            cnt  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_op[i]   <= '0;
                e_tag[i]  <= '0;
                e_o1[i]   <= '0;
                e_o2[i]   <= '0;
                e_rank[i] <= '0;
            end
        end else if (flush) begin
            e_v <= '0;
            cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (e_v[i]) begin
                    if (e_d1[i] && s1[i][XLEN]) begin
                        e_d1[i] <= 1'b0;
                        e_o1[i] <= s1[i][XLEN-1:0];
                    end
                    if (e_d2[i] && s2[i][XLEN]) begin
                        e_d2[i] <= 1'b0;
                        e_o2[i] <= s2[i][XLEN-1:0];
                    end
                    if (issue && e_rank[i] > sel_rank) e_rank[i] <= e_rank[i] - CW'(1);
                end
            end
            if (issue) e_v[sel_idx] <= 1'b0;
            if (accept) begin
                e_v[free_idx]    <= 1'b1;
                e_op[free_idx]   <= bus.in_op;
                e_tag[free_idx]  <= bus.in_tag;
                e_d1[free_idx]   <= bus.in_op1_dep && !in_s1[XLEN];
                e_o1[free_idx]   <= (bus.in_op1_dep && in_s1[XLEN]) ? in_s1[XLEN-1:0] : bus.in_op1;
                e_d2[free_idx]   <= bus.in_op2_dep && !in_s2[XLEN];
                e_o2[free_idx]   <= (bus.in_op2_dep && in_s2[XLEN]) ? in_s2[XLEN-1:0] : bus.in_op2;
                e_rank[free_idx] <= cnt - CW'(issue);
            end
            cnt <= cnt + CW'(accept) - CW'(issue);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            it       <= '0;
            d_tag    <= '0;
            d_is_rem <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            out_v    <= 1'b0;
            out_t    <= '0;
            out_d    <= '0;
        end else if (flush) begin
            out_v <= 1'b0;
        end else begin
            if (out_v && bus.out_ready) out_v <= 1'b0;
            unique case (dstate)
                D_IDLE: if (issue) begin
                    d_tag    <= e_tag[sel_idx];
                    d_is_rem <= sel_op[1];
                    it       <= '0;
                    // special cases skip iteration and hold final, already-signed results
                    if (div0 || ovf) begin
                        quo   <= div0 ? '1 : MIN_VAL;
                        rem   <= div0 ? op_a : '0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else begin
                        quo   <= mag_a;
                        rem   <= '0;
                        dvs   <= mag_b;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                    end
                end
                D_BUSY: begin
                    quo <= {quo[XLEN-2:0], ge};
                    rem <= ge ? diff[XLEN-1:0] : shift[XLEN-1:0];
                    it  <= it + ITW'(1);
                end
                D_FIN: begin
                    out_v <= 1'b1;
                    out_t <= d_tag;
                    out_d <= d_is_rem ? r_fix : q_fix;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_div_param.sv
// Scoreboard bench for rs_div_param: directed dispatches push expected results,
// an independent monitor pops and compares on every output handshake.
module tb_rs_div_param;
    localparam int XLEN = 32, TAG_W = 5, DEPTH = 8, NUM_WB = 3;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t exp_q [$];

    rs_div_param_if #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH), .NUM_WB(NUM_WB)) bus ();

    rs_div_param #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got tag %0d val %h, required no result", bus.out_tag, bus.out_val);
            end else begin
                e = exp_q.pop_front();
                check("result_tag", 64'(bus.out_tag), 64'(e.tag));
                check("result_val", 64'(bus.out_val), 64'(e.val));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                            input logic d1, input logic [XLEN-1:0] a,
                            input logic d2, input logic [XLEN-1:0] b, output int acc);
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_tag     = tag;
        bus.in_op1_dep = d1;
        bus.in_op1     = a;
        bus.in_op2_dep = d2;
        bus.in_op2     = b;
        tick();
        bus.in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic push(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
        exp_q.push_back('{tag: tag, val: val});
    endtask

    task automatic wb1(input int port, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
        bus.wb_en[port] = 1'b1;
        bus.wb_tag[port*TAG_W +: TAG_W] = tag;
        bus.wb_val[port*XLEN +: XLEN] = val;
    endtask

    task automatic wait_valid(input int max, output int edge_c);
        edge_c = -1;
        for (int i = 0; i < max; i++) begin
            if (bus.out_valid) begin
                edge_c = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        tick();
        tick();
    endtask

    task automatic quiet(input string name, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        check(name, 64'(seen), 64'd0);
    endtask

    logic [1:0]       t_op  [8] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10};
    logic [XLEN-1:0]  t_a   [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                    32'd7, 32'd7, 32'h80000000, 32'hFFFFFFFB};
    logic [XLEN-1:0]  t_b   [8] = '{32'd2, 32'd2, 32'd7, 32'd7,
                                    32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0};
    logic [XLEN-1:0]  t_exp [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                    32'hFFFFFFFD, 32'd1, 32'h80000000, 32'hFFFFFFFB};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        int acc, a0, e;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_tag = '0;
        bus.in_op1_dep = 1'b0; bus.in_op1 = '0; bus.in_op2_dep = 1'b0; bus.in_op2 = '0;
        bus.wb_en = '0; bus.wb_tag = '0; bus.wb_val = '0; bus.out_ready = 1'b1;

        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_out_val", 64'(bus.out_val), 64'd0);
        tick(); tick();
        rst = 1'b1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // reset in the middle of a divide, with one blocked entry live
        dispatch(2'b01, 5'd2, 1'b1, 32'd31, 1'b0, 32'd1, acc);
        dispatch(2'b01, 5'd1, 1'b0, 32'd100, 1'b0, 32'd7, acc);
        for (int i = 0; i < 9; i++) tick();
        check("pre_rst_count", 64'(bus.count), 64'd1);
        rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_count", 64'(bus.count), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_count", 64'(bus.count), 64'd0);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        quiet("no_result_after_rst", 40);

        // normal and special-case divides, back to back
        for (int i = 0; i < 8; i++) begin
            push(TAG_W'(i + 2), t_exp[i]);
            dispatch(t_op[i], TAG_W'(i + 2), 1'b0, t_a[i], 1'b0, t_b[i], acc);
            if (i == 0) a0 = acc;
        end
        wait_valid(60, e);
        check("div_latency", 64'(e - a0), 64'd34);
        wait_drain(400);

        push(5'd10, 32'hFFFFFFFF);
        dispatch(2'b01, 5'd10, 1'b0, 32'd5, 1'b0, 32'd0, acc);
        wait_valid(10, e);
        check("div0_latency", 64'(e - acc), 64'd2);
        wait_drain(10);
        push(5'd11, 32'd0);
        dispatch(2'b10, 5'd11, 1'b0, 32'h80000000, 1'b0, 32'hFFFFFFFF, acc);
        wait_valid(10, e);
        check("ovf_latency", 64'(e - acc), 64'd2);
        wait_drain(10);

        // wakeup priority and age order while the divider is busy
        push(5'd12, 32'd100);
        dispatch(2'b01, 5'd12, 1'b0, 32'd1000, 1'b0, 32'd10, acc);
        push(5'd13, 32'd21);
        dispatch(2'b01, 5'd13, 1'b1, 32'd3, 1'b0, 32'd2, acc);
        push(5'd14, 32'd10);
        dispatch(2'b01, 5'd14, 1'b0, 32'd50, 1'b0, 32'd5, acc);
        wb1(1, 5'd3, 32'd42);
        wb1(2, 5'd3, 32'd99);
        tick();
        bus.wb_en = '0;
        push(5'd15, 32'd10);
        wb1(0, 5'd7, 32'd4);
        dispatch(2'b01, 5'd15, 1'b0, 32'd40, 1'b1, 32'd7, acc);
        bus.wb_en = '0;
        wait_drain(300);

        // fill, overflow attempt, single wakeup
        for (int k = 0; k < 8; k++)
            dispatch(2'b01, TAG_W'(k), 1'b1, 32'(16 + k), 1'b0, 32'(k + 1), acc);
        check("full_count", 64'(bus.count), 64'd8);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1; bus.in_op = 2'b01; bus.in_tag = 5'd30;
        bus.in_op1_dep = 1'b0; bus.in_op1 = 32'd6; bus.in_op2_dep = 1'b0; bus.in_op2 = 32'd3;
        tick(); tick(); tick();
        check("full_drop_count", 64'(bus.count), 64'd8);
        bus.in_valid = 1'b0;
        wb1(0, 5'd16, 32'd100);
        tick();
        bus.wb_en = '0;
        check("woken_not_yet_issued", 64'(bus.count), 64'd8);
        tick();
        check("issue_count", 64'(bus.count), 64'd7);
        check("issue_in_ready", 64'(bus.in_ready), 64'd1);
        push(5'd0, 32'd100);

        // output backpressure stalls issue, then flush clears everything
        bus.out_ready = 1'b0;
        wb1(0, 5'd17, 32'd50);
        tick();
        bus.wb_en = '0;
        wait_valid(60, e);
        check("held_tag", 64'(bus.out_tag), 64'd0);
        check("held_val", 64'(bus.out_val), 64'd100);
        for (int i = 0; i < 5; i++) tick();
        check("stall_count", 64'(bus.count), 64'd7);
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_val", 64'(bus.out_val), 64'd100);
        flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_op = 2'b01; bus.in_tag = 5'd29;
        bus.in_op1 = 32'd8; bus.in_op2 = 32'd2;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_count", 64'(bus.count), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        quiet("no_result_after_flush", 40);

        push(5'd9, 32'd3);
        dispatch(2'b01, 5'd9, 1'b0, 32'd9, 1'b0, 32'd3, acc);
        wait_drain(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
